vga_mode_scheduler: RTL and testbench
=====================================

Name: vga_mode_scheduler

Overview:
- Frame-synchronous controller that selects the display mode for the VGA pattern generator.
- Output is a 5-bit one-hot mode code: WHITE, BLACK, RED, GREEN, MONITOR.
- Mode advances either automatically after a programmable number of frames, or on a debounced key pulse.
- Every mode change is deferred to the vsync assertion edge, so the picture never tears mid-frame. The block sits between the key debouncer and the VGA data generator.

Parameters:
- DWELL_FRAMES, 60: frames a mode is held before auto-advance. 0 disables auto-advance (manual only).
- CNT_W, 8: dwell counter width. DWELL_FRAMES must be ≤ 2^CNT_W-1.
- VS_ACT_LOW, 1: 1 means vsync is active-low; 0 means active-high.

Ports:
- clk  in  1  pixel clock, single clock domain.
- rst  in  1  asynchronous, active-high reset.
- vsync  in  1  vertical sync from the timing generator, same clock domain.
- key_next  in  1  one-cycle pulse: request advance to the next mode.
- key_pause  in  1  one-cycle pulse: toggle auto-advance pause.
- mode  out  5  one-hot mode. WHITE=00001, BLACK=00010, RED=00100, GREEN=01000, MONITOR=10000.
- mode_chg  out  1  one-cycle pulse in the first cycle the new mode is visible.
- paused  out  1  1 while auto-advance is paused.
- dwell_cnt  out  CNT_W  frames elapsed in the current mode.

Behaviour:
- Interface (already decided): one clock, clk; reset rst is asynchronous and active-high.
- Reset values: mode=00001 (WHITE), mode_chg=0, paused=0, dwell_cnt=0, pending=0, vs_r=inactive level.
- Frame tick:
  - vs_r registers vsync each cycle.
  - tick = act(vsync) & ~act(vs_r), combinational, where act() applies VS_ACT_LOW.
  - Exactly one tick per vsync assertion. A vsync held active produces no further ticks.
- Pending request:
  - key_next sets pending=1.
  - Any number of key_next pulses between two ticks collapse into a single advance.
  - key_next in the same cycle as tick counts as pending for that tick.
- Pause:
  - key_pause toggles paused on the next clock edge. This is not frame-aligned.
  - dwell_cnt is frozen while paused and resumes from its held value.
- Per-tick decision, registered at the tick clock edge, in priority order:
  1. pending or key_next: mode←next(mode), dwell_cnt←0, pending←0, mode_chg←1. This applies even while paused.
  2. Else if !paused and DWELL_FRAMES≠0 and dwell_cnt==DWELL_FRAMES-1: mode←next(mode), dwell_cnt←0, mode_chg←1.
  3. Else if !paused: dwell_cnt←dwell_cnt+1, saturating at 2^CNT_W-1 (reachable only when DWELL_FRAMES=0).
  4. Else hold.
- Advance order: WHITE→BLACK→RED→GREEN→MONITOR→WHITE, wrapping.
- Non-one-hot mode (SEU or X): recovers to WHITE on the next clock edge with mode_chg=1, and dwell_cnt←0.
- Latency: the new mode is visible in the cycle after the tick cycle; mode_chg is high in that same cycle only.
- Simultaneous key_pause and tick: the tick decision uses the pre-toggle paused value.
- Reset mid-frame: all state clears immediately. The first tick after reset counts normally.

Optional Feature:
- Macro: VGA_MODE_MASK_EN.
- With the macro defined:
  - Adds input mode_mask[4:0]; bit i=1 enables the mode with one-hot bit i.
  - next() skips disabled modes, searching in advance order.
  - If the current mode becomes disabled, it is replaced at the next tick as an advance.
  - If mode_mask==0, mode is forced to WHITE and holds.
- Without the macro: all five modes are enabled and no mode_mask port exists.

Decomposition:
- Package vga_mode_pkg holds:
  - one-hot constants MODE_WHITE..MODE_MONITOR and MODE_W=5;
  - function next_mode(mode, mask) implementing advance, skip and recovery.
- The VGA data generator imports the same constants.
- One sub-module, vga_frame_tick: vsync register, polarity, and edge detect producing tick.

Test Plan:
- Reset with DWELL_FRAMES=3, then 3 vsync assertions → mode 00001→00010 after the 3rd tick; mode_chg pulses once; dwell_cnt goes 0,1,2,0.
- Three key_next pulses inside one frame, then a tick → mode advances by exactly one (WHITE→BLACK); pending clears.
- key_pause, then 10 ticks → mode holds, paused=1, dwell_cnt frozen at its value. key_next while paused, then a tick → advances once. key_pause again → auto-advance resumes counting from the held value.
- Start at MONITOR (10000) and advance → wraps to 00001. Force mode=00011 → next edge gives 00001 with mode_chg=1.
- vsync held active for 100 cycles → one tick only. Set VS_ACT_LOW=0 and repeat with inverted vsync → identical mode trace.
- With VGA_MODE_MASK_EN and mask=10100 from WHITE, then a tick → RED; next advance → MONITOR; mask=00000 → WHITE holds.

Source files
------------

// File: rtl/vga_mode_pkg.sv
// ---------------------------------------------------------------------------
// vga_mode_pkg : one-hot display mode codes and the mode advance function
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package vga_mode_pkg;

  localparam int MODE_W = 5;

  localparam logic [MODE_W-1:0] MODE_WHITE   = 5'b00001;
  localparam logic [MODE_W-1:0] MODE_BLACK   = 5'b00010;
  localparam logic [MODE_W-1:0] MODE_RED     = 5'b00100;
  localparam logic [MODE_W-1:0] MODE_GREEN   = 5'b01000;
  localparam logic [MODE_W-1:0] MODE_MONITOR = 5'b10000;

  // Rotate left to the next enabled mode; a corrupt code or an empty mask yields WHITE.
  function automatic logic [MODE_W-1:0] next_mode(input logic [MODE_W-1:0] cur,
                                                  input logic [MODE_W-1:0] mask);
    logic [MODE_W-1:0] cand;
    logic              found;
    next_mode = MODE_WHITE;
    found     = 1'b0;
    cand      = cur;
    if ((mask != '0) && $onehot(cur)) begin
      for (int i = 0; i < MODE_W; i++) begin
        cand = {cand[MODE_W-2:0], cand[MODE_W-1]};
        if (!found && ((cand & mask) != '0)) begin
          next_mode = cand;
          found     = 1'b1;
        end
      end
    end
  endfunction

endpackage

`default_nettype wire

// File: rtl/vga_frame_tick.sv
// ---------------------------------------------------------------------------
// vga_frame_tick : registers vsync and emits one tick per vsync assertion edge
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module vga_frame_tick #(
  parameter int VS_ACT_LOW = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic vsync,
  output logic tick
);

  localparam logic INACTIVE = (VS_ACT_LOW != 0);

  logic vs_r;
  logic act_now;
  logic act_prev;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vs_r <= INACTIVE;
    end else begin
      vs_r <= vsync;
    end
  end

  assign act_now  = vsync ^ INACTIVE;
  assign act_prev = vs_r ^ INACTIVE;
  assign tick     = act_now & ~act_prev;

endmodule

`default_nettype wire

// File: rtl/vga_mode_scheduler.sv
// ---------------------------------------------------------------------------
// vga_mode_scheduler : frame-synchronous display mode selector (optional
// VGA_MODE_MASK_EN adds a per-mode enable mask). Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module vga_mode_scheduler
  import vga_mode_pkg::*;
#(
  parameter int DWELL_FRAMES = 60,
  parameter int CNT_W        = 8,
  parameter int VS_ACT_LOW   = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              vsync,
  input  logic              key_next,
  input  logic              key_pause,
`ifdef VGA_MODE_MASK_EN
  input  logic [MODE_W-1:0] mode_mask,
`endif
  output logic [MODE_W-1:0] mode,
  output logic              mode_chg,
  output logic              paused,
  output logic [CNT_W-1:0]  dwell_cnt
);

  localparam logic             AUTO_EN    = (DWELL_FRAMES != 0);
  localparam logic [CNT_W-1:0] DWELL_LAST = CNT_W'((DWELL_FRAMES == 0) ? 0 : DWELL_FRAMES - 1);

  logic              tick;
  logic              pending;
  logic [MODE_W-1:0] enable_mask;
  logic              mode_ok;
  logic              mode_en;

`ifdef VGA_MODE_MASK_EN
  assign enable_mask = mode_mask;
`else
  assign enable_mask = '1;
`endif

  assign mode_ok = $onehot(mode);
  assign mode_en = (mode & enable_mask) != '0;

  vga_frame_tick #(
    .VS_ACT_LOW (VS_ACT_LOW)
  ) u_frame_tick (
    .clk   (clk),
    .rst   (rst),
    .vsync (vsync),
    .tick  (tick)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mode      <= MODE_WHITE;
      mode_chg  <= 1'b0;
      paused    <= 1'b0;
      dwell_cnt <= '0;
      pending   <= 1'b0;
    end else begin
      mode_chg <= 1'b0;
      if (key_pause) paused <= ~paused;
      // Later pending clears in the advance branches override this set.
      if (key_next) pending <= 1'b1;

      if (!mode_ok) begin
        mode      <= MODE_WHITE;
        mode_chg  <= 1'b1;
        dwell_cnt <= '0;
      end
`ifdef VGA_MODE_MASK_EN
      else if (enable_mask == '0) begin
        mode      <= MODE_WHITE;
        mode_chg  <= (mode != MODE_WHITE);
        dwell_cnt <= '0;
        pending   <= 1'b0;
      end
`endif
      else if (tick) begin
        // Tick decisions see the pre-toggle paused value.
        if (pending || key_next || !mode_en) begin
          mode      <= next_mode(mode, enable_mask);
          mode_chg  <= 1'b1;
          dwell_cnt <= '0;
          pending   <= 1'b0;
        end else if (!paused && AUTO_EN && (dwell_cnt == DWELL_LAST)) begin
          mode      <= next_mode(mode, enable_mask);
          mode_chg  <= 1'b1;
          dwell_cnt <= '0;
        end else if (!paused && (dwell_cnt != '1)) begin
          dwell_cnt <= dwell_cnt + 1'b1;
        end
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_vga_mode_scheduler.sv
// ---------------------------------------------------------------------------
// tb_vga_mode_scheduler : table-driven scoreboard bench, both vsync polarities
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_vga_mode_scheduler;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       vs_act = 1'b0;
  logic       key_next = 1'b0;
  logic       key_pause = 1'b0;
  logic [4:0] mask = 5'b11111;

  logic       vsync_l, vsync_h;
  logic [4:0] mode_l, mode_h;
  logic       chg_l, chg_h, paused_l, paused_h;
  logic [7:0] dwell_l, dwell_h;

  int n_chk  = 0;
  int n_fail = 0;

  typedef struct {
    bit          kn;
    bit          kp;
    bit          tk;
    logic [14:0] exp;
  } vec_t;

  vec_t        vec[$];
  logic [14:0] sb_q[$];

  assign vsync_l = ~vs_act;
  assign vsync_h = vs_act;

  always #5 clk = ~clk;

  vga_mode_scheduler #(.DWELL_FRAMES(3), .CNT_W(8), .VS_ACT_LOW(1)) dut_l (
    .clk(clk), .rst(rst), .vsync(vsync_l), .key_next(key_next), .key_pause(key_pause),
`ifdef VGA_MODE_MASK_EN
    .mode_mask(mask),
`endif
    .mode(mode_l), .mode_chg(chg_l), .paused(paused_l), .dwell_cnt(dwell_l));

  vga_mode_scheduler #(.DWELL_FRAMES(3), .CNT_W(8), .VS_ACT_LOW(0)) dut_h (
    .clk(clk), .rst(rst), .vsync(vsync_h), .key_next(key_next), .key_pause(key_pause),
`ifdef VGA_MODE_MASK_EN
    .mode_mask(mask),
`endif
    .mode(mode_h), .mode_chg(chg_h), .paused(paused_h), .dwell_cnt(dwell_h));

  function automatic logic [14:0] ex(input logic [4:0] m, input logic c, input logic p,
                                     input logic [7:0] d);
    return {m, c, p, d};
  endfunction

  task automatic check(input string name, input logic [14:0] exp);
    n_chk++;
    if ({mode_l, chg_l, paused_l, dwell_l} !== exp) begin
      n_fail++;
      $display("FAIL %s [active-low] got mode=%b chg=%b paused=%b dwell=%0d expected mode=%b chg=%b paused=%b dwell=%0d",
               name, mode_l, chg_l, paused_l, dwell_l, exp[14:10], exp[9], exp[8], exp[7:0]);
    end
    n_chk++;
    if ({mode_h, chg_h, paused_h, dwell_h} !== exp) begin
      n_fail++;
      $display("FAIL %s [active-high] got mode=%b chg=%b paused=%b dwell=%0d expected mode=%b chg=%b paused=%b dwell=%0d",
               name, mode_h, chg_h, paused_h, dwell_h, exp[14:10], exp[9], exp[8], exp[7:0]);
    end
  endtask

  // One stimulus cycle then one quiet cycle; the quiet cycle must drop mode_chg.
  task automatic drive(input string name, input bit kn, input bit kp, input bit tk,
                       input logic [14:0] exp);
    logic [14:0] e;
    @(negedge clk);
    key_next = kn; key_pause = kp; vs_act = tk;
    sb_q.push_back(exp);
    @(posedge clk); #1;
    e = sb_q.pop_front();
    check(name, e);
    @(negedge clk);
    key_next = 1'b0; key_pause = 1'b0; vs_act = 1'b0;
    sb_q.push_back({exp[14:10], 1'b0, exp[8:0]});
    @(posedge clk); #1;
    e = sb_q.pop_front();
    check({name, "_idle"}, e);
  endtask

  function automatic void add(input bit kn, input bit kp, input bit tk, input logic [14:0] e);
    vec.push_back('{kn: kn, kp: kp, tk: tk, exp: e});
  endfunction

  initial begin
    // Expected sequence with DWELL_FRAMES = 3.
    add(0, 0, 1, ex(5'b00001, 0, 0, 1));
    add(0, 0, 1, ex(5'b00001, 0, 0, 2));
    add(0, 0, 1, ex(5'b00010, 1, 0, 0));
    for (int i = 0; i < 3; i++) add(1, 0, 0, ex(5'b00010, 0, 0, 0));
    add(0, 0, 1, ex(5'b00100, 1, 0, 0));
    add(0, 0, 1, ex(5'b00100, 0, 0, 1));
    add(0, 1, 0, ex(5'b00100, 0, 1, 1));
    for (int i = 0; i < 10; i++) add(0, 0, 1, ex(5'b00100, 0, 1, 1));
    add(1, 0, 0, ex(5'b00100, 0, 1, 1));
    add(0, 0, 1, ex(5'b01000, 1, 1, 0));
    add(0, 0, 1, ex(5'b01000, 0, 1, 0));
    add(0, 1, 0, ex(5'b01000, 0, 0, 0));
    add(0, 0, 1, ex(5'b01000, 0, 0, 1));
    add(0, 1, 0, ex(5'b01000, 0, 1, 1));
    add(0, 0, 1, ex(5'b01000, 0, 1, 1));
    add(0, 1, 0, ex(5'b01000, 0, 0, 1));
    add(0, 0, 1, ex(5'b01000, 0, 0, 2));
    add(0, 0, 1, ex(5'b10000, 1, 0, 0));
    add(1, 0, 1, ex(5'b00001, 1, 0, 0));
    add(0, 1, 1, ex(5'b00001, 0, 1, 1));
    add(0, 1, 0, ex(5'b00001, 0, 0, 1));

    repeat (2) @(posedge clk);
    #1 check("reset_hold", ex(5'b00001, 0, 0, 0));
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1 check("reset_release", ex(5'b00001, 0, 0, 0));

    for (int i = 0; i < vec.size(); i++)
      drive($sformatf("vec%0d", i), vec[i].kn, vec[i].kp, vec[i].tk, vec[i].exp);

    // vsync held active: a single tick only.
    @(negedge clk); vs_act = 1'b1;
    @(posedge clk); #1 check("hold_first_tick", ex(5'b00001, 0, 0, 2));
    repeat (99) @(posedge clk);
    #1 check("hold_no_more_ticks", ex(5'b00001, 0, 0, 2));
    @(negedge clk); vs_act = 1'b0;
    drive("hold_then_tick", 0, 0, 1, ex(5'b00010, 1, 0, 0));

    // Corrupt mode code recovers to WHITE on the next edge.
    @(negedge clk);
    force dut_l.mode = 5'b00011;
    force dut_h.mode = 5'b00011;
    #1;
    release dut_l.mode;
    release dut_h.mode;
    @(posedge clk); #1 check("seu_recover", ex(5'b00001, 1, 0, 0));
    @(posedge clk); #1 check("seu_settle", ex(5'b00001, 0, 0, 0));

    // Asynchronous reset mid-frame, then the first tick counts normally.
    drive("pre_rst_tick", 0, 0, 1, ex(5'b00001, 0, 0, 1));
    drive("pre_rst_pause", 0, 1, 0, ex(5'b00001, 0, 1, 1));
    @(negedge clk); vs_act = 1'b1; key_next = 1'b1;
    #2 rst = 1'b1;
    #1 check("async_reset", ex(5'b00001, 0, 0, 0));
    @(negedge clk); rst = 1'b0; vs_act = 1'b0; key_next = 1'b0;
    drive("post_rst_tick", 0, 0, 1, ex(5'b00001, 0, 0, 1));

`ifdef VGA_MODE_MASK_EN
    @(negedge clk); mask = 5'b10100;
    @(posedge clk); #1 check("mask_no_tick", ex(5'b00001, 0, 0, 1));
    drive("mask_replace", 0, 0, 1, ex(5'b00100, 1, 0, 0));
    drive("mask_key", 1, 0, 0, ex(5'b00100, 0, 0, 0));
    drive("mask_skip", 0, 0, 1, ex(5'b10000, 1, 0, 0));
    @(negedge clk); mask = 5'b00000;
    @(posedge clk); #1 check("mask_zero", ex(5'b00001, 1, 0, 0));
    drive("mask_zero_hold", 0, 0, 1, ex(5'b00001, 0, 0, 0));
    @(negedge clk); mask = 5'b11111;
`endif

    if (sb_q.size() != 0) begin
      n_chk++;
      n_fail++;
      $display("FAIL scoreboard_drain got %0d leftover entries expected 0", sb_q.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
